// File: rtl/axis_slave.sv
// AXI-Stream slave receiver: show-ahead FIFO between an AXIS link and a backend
// consumer, with packet counting, pop-of-last pulse, stall timeout and overrun flag.
module axis_slave #(
    parameter int FIFO_DEPTH     = 8,
    parameter int BK_RDY_TIMEOUT = 5
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        axis_tvalid,
    input  logic [31:0] axis_tdata,
    input  logic [3:0]  axis_tstrb,
    input  logic [3:0]  axis_tkeep,
    input  logic        axis_tlast,
    input  logic [1:0]  axis_tuser,
    output logic        axis_tready,
    output logic        bk_valid,
    output logic [31:0] bk_data,
    output logic [3:0]  bk_tstrb,
    output logic [3:0]  bk_tkeep,
    output logic [1:0]  bk_user,
    output logic        bk_last,
    input  logic        bk_ready,
    input  logic        bk_flush,
    output logic [7:0]  bk_pkt_cnt,
    output logic        bk_pkt_done,
    output logic        bk_stall,
    output logic        bk_overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 43;
    localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   occ;
    logic [7:0]    stall_cnt;
    logic          push;
    logic          pop;
    logic          pkt_inc;
    logic          pkt_dec;

    // Extra pointer bit lets occupancy reach FIFO_DEPTH without a reserved slot.
    assign occ         = wr_ptr - rd_ptr;
    assign axis_tready = (occ != FULL_OCC) | bk_flush;
    assign bk_valid    = (occ != '0);

    // A flush discards any transfer in its cycle, including the accepted upstream beat.
    assign push    = axis_tvalid & axis_tready & ~bk_flush;
    assign pop     = bk_valid & bk_ready & ~bk_flush;
    assign pkt_inc = push & axis_tlast;
    assign pkt_dec = pop & bk_last;

    assign head = bk_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last} = head;

    assign bk_stall = (int'(stall_cnt) >= BK_RDY_TIMEOUT);

    always_ff @(posedge axi_aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast};
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bk_pkt_cnt  <= '0;
            bk_pkt_done <= 1'b0;
            stall_cnt   <= '0;
            bk_overrun  <= 1'b0;
        end else begin
            bk_pkt_done <= pkt_dec;
            if (bk_flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                bk_pkt_cnt <= '0;
                stall_cnt  <= '0;
                bk_overrun <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;

                if (pkt_inc && !pkt_dec && bk_pkt_cnt != 8'hFF) begin
                    bk_pkt_cnt <= bk_pkt_cnt + 8'd1;
                end else if (pkt_dec && !pkt_inc && bk_pkt_cnt != 8'h00) begin
                    bk_pkt_cnt <= bk_pkt_cnt - 8'd1;
                end

                if (pop || !bk_valid) begin
                    stall_cnt <= '0;
                end else if (stall_cnt != 8'hFF) begin
                    stall_cnt <= stall_cnt + 8'd1;
                end

                // Full buffer with no packet end means the consumer can never drain a packet.
                if (occ == FULL_OCC && bk_pkt_cnt == 8'h00) begin
                    bk_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_slave.sv
// Directed bench for axis_slave: single beat, fill/drain, overrun, streaming,
// stall timeout and asynchronous reset mid-packet.
module tb_axis_slave;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic        axis_tvalid;
    logic [31:0] axis_tdata;
    logic [3:0]  axis_tstrb;
    logic [3:0]  axis_tkeep;
    logic        axis_tlast;
    logic [1:0]  axis_tuser;
    logic        axis_tready;
    logic        bk_valid;
    logic [31:0] bk_data;
    logic [3:0]  bk_tstrb;
    logic [3:0]  bk_tkeep;
    logic [1:0]  bk_user;
    logic        bk_last;
    logic        bk_ready;
    logic        bk_flush;
    logic [7:0]  bk_pkt_cnt;
    logic        bk_pkt_done;
    logic        bk_stall;
    logic        bk_overrun;

    int n_chk = 0;
    int n_bad = 0;

    axis_slave #(.FIFO_DEPTH(8), .BK_RDY_TIMEOUT(5)) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .axis_tvalid (axis_tvalid),
        .axis_tdata  (axis_tdata),
        .axis_tstrb  (axis_tstrb),
        .axis_tkeep  (axis_tkeep),
        .axis_tlast  (axis_tlast),
        .axis_tuser  (axis_tuser),
        .axis_tready (axis_tready),
        .bk_valid    (bk_valid),
        .bk_data     (bk_data),
        .bk_tstrb    (bk_tstrb),
        .bk_tkeep    (bk_tkeep),
        .bk_user     (bk_user),
        .bk_last     (bk_last),
        .bk_ready    (bk_ready),
        .bk_flush    (bk_flush),
        .bk_pkt_cnt  (bk_pkt_cnt),
        .bk_pkt_done (bk_pkt_done),
        .bk_stall    (bk_stall),
        .bk_overrun  (bk_overrun)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    initial begin
        axi_aresetn = 1'b0;
        axis_tvalid = 1'b0;
        axis_tdata  = '0;
        axis_tstrb  = 4'hF;
        axis_tkeep  = 4'hF;
        axis_tlast  = 1'b0;
        axis_tuser  = 2'b00;
        bk_ready    = 1'b0;
        bk_flush    = 1'b0;
        tick();
        tick();
        axi_aresetn = 1'b1;
        tick();

        check("rst_tready",  32'(axis_tready), 32'd1);
        check("rst_valid",   32'(bk_valid),    32'd0);
        check("rst_data",    bk_data,          32'd0);
        check("rst_pkt_cnt", 32'(bk_pkt_cnt),  32'd0);
        check("rst_done",    32'(bk_pkt_done), 32'd0);
        check("rst_stall",   32'(bk_stall),    32'd0);
        check("rst_overrun", 32'(bk_overrun),  32'd0);

        // Single beat with tlast
        axis_tvalid = 1'b1;
        axis_tdata  = 32'hA5A5_0001;
        axis_tlast  = 1'b1;
        axis_tuser  = 2'b10;
        bk_ready    = 1'b1;
        tick();
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        check("sb_valid",   32'(bk_valid),   32'd1);
        check("sb_data",    bk_data,         32'hA5A5_0001);
        check("sb_last",    32'(bk_last),    32'd1);
        check("sb_user",    32'(bk_user),    32'd2);
        check("sb_pkt_cnt", 32'(bk_pkt_cnt), 32'd1);
        tick();
        check("sb_done",     32'(bk_pkt_done), 32'd1);
        check("sb_pkt_cnt0", 32'(bk_pkt_cnt),  32'd0);
        check("sb_empty",    32'(bk_valid),    32'd0);
        check("sb_data0",    bk_data,          32'd0);
        tick();
        check("sb_done_end", 32'(bk_pkt_done), 32'd0);

        // Fill to full, then drain in order
        bk_ready = 1'b0;
        axis_tuser = 2'b00;
        for (int i = 0; i < 8; i++) begin
            axis_tvalid = 1'b1;
            axis_tdata  = 32'(i);
            axis_tlast  = (i == 7);
            tick();
        end
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        check("fill_tready",  32'(axis_tready), 32'd0);
        check("fill_pkt_cnt", 32'(bk_pkt_cnt),  32'd1);
        tick();
        check("fill_overrun", 32'(bk_overrun),  32'd0);
        bk_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 32'(bk_valid), 32'd1);
            check("drain_data",  bk_data,       32'(i));
            check("drain_last",  32'(bk_last),  (i == 7) ? 32'd1 : 32'd0);
            if (i == 0) check("drain_tready_pre", 32'(axis_tready), 32'd0);
            tick();
            if (i == 0) check("drain_tready_post", 32'(axis_tready), 32'd1);
        end
        check("drain_empty",   32'(bk_valid),    32'd0);
        check("drain_done",    32'(bk_pkt_done), 32'd1);
        check("drain_pkt_cnt", 32'(bk_pkt_cnt),  32'd0);

        // Overrun: full buffer without any tlast
        bk_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            axis_tvalid = 1'b1;
            axis_tdata  = 32'h200 + 32'(i);
            tick();
        end
        axis_tvalid = 1'b0;
        check("ovr_pre", 32'(bk_overrun), 32'd0);
        tick();
        check("ovr_set", 32'(bk_overrun), 32'd1);
        tick();
        tick();
        check("ovr_sticky", 32'(bk_overrun), 32'd1);
        bk_flush    = 1'b1;
        axis_tvalid = 1'b1;
        axis_tdata  = 32'hDEAD_BEEF;
        #1;
        check("flush_tready", 32'(axis_tready), 32'd1);
        tick();
        bk_flush    = 1'b0;
        axis_tvalid = 1'b0;
        check("flush_valid",   32'(bk_valid),   32'd0);
        check("flush_overrun", 32'(bk_overrun), 32'd0);
        check("flush_tready2", 32'(axis_tready), 32'd1);
        check("flush_pkt_cnt", 32'(bk_pkt_cnt), 32'd0);

        // Streaming push and pop every cycle
        bk_ready    = 1'b1;
        axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            axis_tdata = 32'd100 + 32'(i);
            tick();
            check("strm_valid",  32'(bk_valid),    32'd1);
            check("strm_data",   bk_data,          32'd100 + 32'(i));
            check("strm_tready", 32'(axis_tready), 32'd1);
        end
        axis_tvalid = 1'b0;
        tick();
        check("strm_empty", 32'(bk_valid), 32'd0);

        // Stall timeout
        bk_ready    = 1'b0;
        axis_tvalid = 1'b1;
        axis_tdata  = 32'h55;
        axis_tlast  = 1'b1;
        tick();
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("stall_hold", 32'(bk_stall), (k >= 5) ? 32'd1 : 32'd0);
        end
        bk_ready = 1'b1;
        tick();
        check("stall_clear", 32'(bk_stall),    32'd0);
        check("stall_done",  32'(bk_pkt_done), 32'd1);
        check("stall_empty", 32'(bk_valid),    32'd0);

        // Asynchronous reset with a partial packet buffered
        bk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            axis_tvalid = 1'b1;
            axis_tdata  = 32'h11 * 32'(i + 1);
            axis_tlast  = (i == 1);
            tick();
        end
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        check("mid_pkt_cnt", 32'(bk_pkt_cnt), 32'd1);
        check("mid_valid",   32'(bk_valid),   32'd1);
        #2;
        axi_aresetn = 1'b0;
        #1;
        check("arst_valid",   32'(bk_valid),    32'd0);
        check("arst_pkt_cnt", 32'(bk_pkt_cnt),  32'd0);
        check("arst_tready",  32'(axis_tready), 32'd1);
        tick();
        tick();
        axi_aresetn = 1'b1;
        tick();
        axis_tvalid = 1'b1;
        axis_tdata  = 32'h0000_BEEF;
        axis_tlast  = 1'b1;
        tick();
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        check("post_data",    bk_data,         32'h0000_BEEF);
        check("post_last",    32'(bk_last),    32'd1);
        check("post_pkt_cnt", 32'(bk_pkt_cnt), 32'd1);
        bk_ready = 1'b1;
        tick();
        check("post_done",  32'(bk_pkt_done), 32'd1);
        check("post_empty", 32'(bk_valid),    32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
